// File: rtl/btn_debounce.sv
// btn_debounce: filters contact bounce on one raw active-low push-button.
// Ports: clk, reset (sync, active-low), btn_n (raw pin, 0 = pressed),
//        db_level (debounced, 1 = pressed), db_tick (one-cycle press pulse).
// Optional BTN_DEBOUNCE_SYNC_EN adds a two-flop synchronizer on btn_n.
module btn_debounce #(
  parameter int N = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic db_level,
  output logic db_tick
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  localparam logic [N-1:0] CMAX = '1;
  localparam logic [N-1:0] DEC  = 1;

  state_t       state;
  logic [N-1:0] cnt;
  logic         sw;

`ifdef BTN_DEBOUNCE_SYNC_EN
  // Flops reset to 1 so a reset looks like a released button.
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], btn_n};
    end
  end

  assign sw = ~sync[1];
`else
  assign sw = ~btn_n;
`endif

  // Outputs are updated on the same edge as the state change, so
  // db_level tracks {ONE, WAIT0} and db_tick marks WAIT1 -> ONE only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ZERO;
      cnt      <= '0;
      db_level <= 1'b0;
      db_tick  <= 1'b0;
    end else begin
      db_tick <= 1'b0;
      case (state)
        ZERO: begin
          if (sw) begin
            state <= WAIT1;
            cnt   <= CMAX;
          end
        end
        WAIT1: begin
          if (!sw) begin
            state <= ZERO;
          end else if (cnt == '0) begin
            state    <= ONE;
            db_level <= 1'b1;
            db_tick  <= 1'b1;
          end else begin
            cnt <= cnt - DEC;
          end
        end
        ONE: begin
          if (!sw) begin
            state <= WAIT0;
            cnt   <= CMAX;
          end
        end
        WAIT0: begin
          if (sw) begin
            state <= ONE;
          end else if (cnt == '0) begin
            state    <= ZERO;
            db_level <= 1'b0;
          end else begin
            cnt <= cnt - DEC;
          end
        end
        default: begin
          state    <= ZERO;
          db_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of btn_debounce with N=4.
// Latencies adapt to whether BTN_DEBOUNCE_SYNC_EN is defined.
module tb_btn_debounce;

  localparam int N = 4;
`ifdef BTN_DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  // Edges from the first sampling edge to the edge that raises db_tick.
  localparam int L = (1 << N) + SL;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b1;
  logic db_level;
  logic db_tick;

  int errs = 0;
  int checks = 0;
  int ticks = 0;
  int t0;

  btn_debounce #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .db_level(db_level),
    .db_tick (db_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (db_tick === 1'b1) ticks++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, leaving time 1 unit after the last one.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reset state, button released.
    reset = 1'b0;
    btn_n = 1'b1;
    run(2);
    check("rst_level", db_level, 0);
    check("rst_tick", db_tick, 0);

    // Reset hold with the button pressed.
    btn_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run(1);
      check("hold_level", db_level, 0);
      check("hold_tick", db_tick, 0);
    end
    reset = 1'b1;
    t0 = ticks;
    run(L);
    check("hold_pre_tick", db_tick, 0);
    check("hold_pre_level", db_level, 0);
    run(1);
    check("hold_tick_hi", db_tick, 1);
    check("hold_level_hi", db_level, 1);
    run(1);
    check("hold_tick_lo", db_tick, 0);
    check("hold_tick_cnt", ticks - t0, 1);

    // Release back to idle.
    btn_n = 1'b1;
    run(L);
    check("rel0_level_hold", db_level, 1);
    run(1);
    check("rel0_level_lo", db_level, 0);
    run(4);

    // Clean press held for 40 cycles, then release.
    t0 = ticks;
    btn_n = 1'b0;
    run(L);
    check("press_pre_tick", db_tick, 0);
    run(1);
    check("press_tick", db_tick, 1);
    check("press_level", db_level, 1);
    run(1);
    check("press_tick_end", db_tick, 0);
    check("press_level_on", db_level, 1);
    run(40 - L - 2);
    btn_n = 1'b1;
    run(L);
    check("release_level_hold", db_level, 1);
    run(1);
    check("release_level_lo", db_level, 0);
    check("release_tick", db_tick, 0);
    run(4);
    check("press_tick_cnt", ticks - t0, 1);

    // Bounce: 10 low, 1 high, then held low.
    t0 = ticks;
    btn_n = 1'b0;
    run(10);
    btn_n = 1'b1;
    run(1);
    btn_n = 1'b0;
    run(L);
    check("bounce_pre_tick", db_tick, 0);
    check("bounce_pre_cnt", ticks - t0, 0);
    run(1);
    check("bounce_tick", db_tick, 1);
    run(5);
    check("bounce_tick_cnt", ticks - t0, 1);

    // Release glitch of 8 cycles while pressed.
    t0 = ticks;
    btn_n = 1'b1;
    run(8);
    btn_n = 1'b0;
    run(30);
    check("glitch_level", db_level, 1);
    check("glitch_tick_cnt", ticks - t0, 0);

    // Release to idle.
    btn_n = 1'b1;
    run(L + 1);
    check("rel1_level_lo", db_level, 0);
    run(4);

    // Reset about 10 cycles into WAIT1.
    t0 = ticks;
    btn_n = 1'b0;
    run(SL + 1 + 10);
    check("midq_level_pre", db_level, 0);
    reset = 1'b0;
    run(1);
    check("midq_level_rst", db_level, 0);
    check("midq_tick_rst", db_tick, 0);
    run(2);
    reset = 1'b1;
    run(L);
    check("midq_pre_tick", db_tick, 0);
    check("midq_pre_cnt", ticks - t0, 0);
    run(1);
    check("midq_tick", db_tick, 1);
    check("midq_level", db_level, 1);
    run(2);
    check("midq_tick_cnt", ticks - t0, 1);

    btn_n = 1'b1;
    run(L + 3);
    check("final_level", db_level, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
